// File: rtl/rs232_rx.sv
// RS-232 receiver: 8N1 frames, mid-bit sampling after a 2-flop synchronizer.
// Reports each byte with valid/pending/ack handshake, framing errors and overruns.
module rs232_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       UART_RX,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       pending,
  output logic       receiving,
  output logic       uart_ferr,
  output logic       uart_ovf
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  logic [1:0] sync_reg;
  logic       rx_s;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= 1'b1;
          else     sync_reg[gi] <= UART_RX;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (rst) sync_reg[gi] <= 1'b1;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign rx_s = sync_reg[1];

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      idx_reg, idx_next;
  logic [7:0]      shift_reg, shift_next;
  logic [7:0]      data_reg, data_next;
  logic            valid_reg, valid_next;
  logic            pending_reg, pending_next;
  logic            ferr_reg, ferr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      pending_reg <= 1'b0;
      ferr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      pending_reg <= pending_next;
      ferr_reg    <= ferr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    idx_next   = idx_reg;
    shift_next = shift_reg;
    data_next  = data_reg;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    // valid wins over a same-cycle ack so the new byte stays pending
    if (valid_reg)  pending_next = 1'b1;
    else if (ack)   pending_next = 1'b0;
    else            pending_next = pending_reg;

    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = START;
      end
      START: begin
        if (cnt_reg == HALF_M1) begin
          cnt_next   = '0;
          idx_next   = '0;
          state_next = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_reg == BIT_M1) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          idx_next   = idx_reg + 3'd1;
          if (idx_reg == 3'd7) state_next = STOP;
        end
      end
      STOP: begin
        if (cnt_reg == BIT_M1) begin
          cnt_next = '0;
          if (rx_s) begin
            data_next  = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = BREAK;
          end
        end
      end
      BREAK: begin
        cnt_next = '0;
        if (rx_s) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign data      = data_reg;
  assign valid     = valid_reg;
  assign pending   = pending_reg;
  assign receiving = (state_reg != IDLE);
  assign uart_ferr = ferr_reg;
  // ack sampled in the valid cycle itself suppresses the overrun
  assign uart_ovf  = valid_reg & pending_reg & ~ack;

endmodule

// File: tb/tb_rs232_rx.sv
// Directed bench for rs232_rx at 16 clocks per bit; a serial driver task
// plays the role of the transmitter and a negedge monitor counts output pulses.
module tb_rs232_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_line = 1'b1;
  logic       ack = 1'b0;
  logic [7:0] data;
  logic       valid, pending, receiving, uart_ferr, uart_ovf;

  int checks = 0;
  int errors = 0;

  rs232_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .UART_RX(rx_line), .ack(ack),
    .data(data), .valid(valid), .pending(pending), .receiving(receiving),
    .uart_ferr(uart_ferr), .uart_ovf(uart_ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vcnt, fcnt, ocnt, ovf_with_valid, last_valid_cyc, dbl;
  logic saw_recv, prev_v, prev_f;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (valid) begin vcnt++; got_q.push_back(data); last_valid_cyc = cyc; end
      if (uart_ferr) fcnt++;
      if (uart_ovf) begin ocnt++; if (valid) ovf_with_valid++; end
      if (receiving) saw_recv = 1'b1;
      if ((valid && prev_v) || (uart_ferr && prev_f)) dbl++;
    end
    prev_v = valid;
    prev_f = uart_ferr;
  end

  task automatic clear_mon();
    vcnt = 0; fcnt = 0; ocnt = 0; ovf_with_valid = 0; dbl = 0;
    saw_recv = 1'b0; last_valid_cyc = -1;
    got_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycles(input int n);
    rx_line = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_not_receiving(input string name);
    int i;
    for (i = 0; i < 300 && receiving; i++) begin @(posedge clk); #1; end
    if (receiving) begin
      checks++; errors++;
      $display("FAIL %s timeout: receiving still %b after 300 cycles", name, receiving);
    end
  endtask

  task automatic do_ack();
    @(negedge clk); ack = 1'b1;
    @(posedge clk); #1; ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_line = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data); end
    checks++; if ({valid, pending, receiving, uart_ferr, uart_ovf} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got %b exp 00000", {valid, pending, receiving, uart_ferr, uart_ovf});
    end
    rst = 1'b0;
    idle_cycles(5);
    clear_mon();
  endtask

  task automatic test_basic_frame();
    int start_cyc, lat;
    clear_mon();
    start_cyc = cyc;
    send_byte(8'hA5, 1'b1);
    idle_cycles(10);
    lat = last_valid_cyc - start_cyc;
    checks++; if (vcnt !== 1) begin errors++; $display("FAIL basic_valid_count got %0d exp 1", vcnt); end
    checks++; if (lat < 150 || lat > 156) begin errors++; $display("FAIL basic_latency got %0d exp 150..156", lat); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", data); end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL basic_pending got %b exp 1", pending); end
    checks++; if (fcnt !== 0) begin errors++; $display("FAIL basic_ferr got %0d exp 0", fcnt); end
    do_ack();
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL basic_ack_clear got %b exp 0", pending); end
    do_ack();
    checks++; if (pending !== 1'b0 || data !== 8'hA5) begin
      errors++; $display("FAIL idle_ack got pending=%b data=%h exp 0 a5", pending, data);
    end
  endtask

  task automatic test_glitch();
    clear_mon();
    rx_line = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle_cycles(30);
    checks++; if (saw_recv !== 1'b1) begin errors++; $display("FAIL glitch_receiving_rose got %b exp 1", saw_recv); end
    checks++; if (receiving !== 1'b0) begin errors++; $display("FAIL glitch_receiving_end got %b exp 0", receiving); end
    checks++; if (vcnt !== 0 || fcnt !== 0) begin
      errors++; $display("FAIL glitch_no_output got valid=%0d ferr=%0d exp 0 0", vcnt, fcnt);
    end
  endtask

  task automatic test_framing_error();
    clear_mon();
    send_byte(8'h3C, 1'b0);
    rx_line = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    checks++; if (receiving !== 1'b1) begin errors++; $display("FAIL ferr_in_break got receiving=%b exp 1", receiving); end
    idle_cycles(8);
    checks++; if (fcnt !== 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", fcnt); end
    checks++; if (vcnt !== 0) begin errors++; $display("FAIL ferr_no_valid got %0d exp 0", vcnt); end
    checks++; if (data !== 8'hA5) begin errors++; $display("FAIL ferr_data_kept got %h exp a5", data); end
    checks++; if (receiving !== 1'b0) begin errors++; $display("FAIL ferr_back_idle got %b exp 0", receiving); end
  endtask

  task automatic test_back_to_back();
    int seen;
    logic acked;
    clear_mon();
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    idle_cycles(12);
    checks++; if (vcnt !== 2) begin errors++; $display("FAIL b2b_valid_count got %0d exp 2", vcnt); end
    checks++; if (ocnt !== 1 || ovf_with_valid !== 1) begin
      errors++; $display("FAIL b2b_ovf got count=%0d with_valid=%0d exp 1 1", ocnt, ovf_with_valid);
    end
    checks++; if (data !== 8'h22) begin errors++; $display("FAIL b2b_data got %h exp 22", data); end
    do_ack();

    clear_mon();
    seen = 0; acked = 1'b0;
    fork
      begin
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        idle_cycles(12);
      end
      begin
        for (int i = 0; i < 400 && !acked; i++) begin
          @(posedge clk); #1;
          if (valid) begin
            seen++;
            if (seen == 2) begin
              ack = 1'b1;
              @(posedge clk); #1;
              ack = 1'b0;
              acked = 1'b1;
            end
          end
        end
      end
    join
    checks++; if (acked !== 1'b1) begin errors++; $display("FAIL b2b_ack_timeout got acked=%b exp 1", acked); end
    checks++; if (vcnt !== 2 || ocnt !== 0) begin
      errors++; $display("FAIL b2b_ack_no_ovf got valid=%0d ovf=%0d exp 2 0", vcnt, ocnt);
    end
    checks++; if (pending !== 1'b1) begin errors++; $display("FAIL b2b_valid_ack_pending got %b exp 1", pending); end
    checks++; if (dbl !== 0) begin errors++; $display("FAIL b2b_single_cycle_pulses got %0d exp 0", dbl); end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    fork
      send_byte(8'hFF, 1'b1);
      begin
        repeat (5 * CPB + 8) @(posedge clk);
        #1; rst = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        checks++; if ({valid, pending, receiving, uart_ferr, uart_ovf} !== 5'b0 || data !== 8'h00) begin
          errors++; $display("FAIL midrst_outputs got flags=%b data=%h exp 00000 00",
                             {valid, pending, receiving, uart_ferr, uart_ovf}, data);
        end
      end
    join
    idle_cycles(20);
    checks++; if (vcnt !== 0 || fcnt !== 0) begin
      errors++; $display("FAIL midrst_no_output got valid=%0d ferr=%0d exp 0 0", vcnt, fcnt);
    end
    send_byte(8'h5A, 1'b1);
    idle_cycles(10);
    checks++; if (vcnt !== 1 || data !== 8'h5A) begin
      errors++; $display("FAIL midrst_next_frame got valid=%0d data=%h exp 1 5a", vcnt, data);
    end
    do_ack();
  endtask

  task automatic test_loopback();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
    clear_mon();
    for (int i = 0; i < 3; i++) begin
      send_byte(exp_b[i], 1'b1);
      idle_cycles(4);
    end
    idle_cycles(10);
    wait_not_receiving("loopback");
    checks++; if (got_q.size() !== 3) begin errors++; $display("FAIL loop_count got %0d exp 3", got_q.size()); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_b[i]) begin
        errors++; $display("FAIL loop_byte%0d got %h exp %h", i, got_q[i], exp_b[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_glitch();
    test_framing_error();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs232_rx.md
RS232_RX -- requirements
Module: rs232_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, sets clock cycles per serial bit period; legal values are 4 to 65535.
REQ-002 Port clk, input, 1 bit, is the single rising-edge clock for all state.
REQ-003 Port rst, input, 1 bit, is the synchronous active-high reset.
REQ-004 Port UART_RX, input, 1 bit, is the asynchronous serial line, idle high, driven by an Rs232Tx UART_TX.
REQ-005 Port ack, input, 1 bit, is the consumer acknowledge that clears the pending byte.
REQ-006 Port data, output, 8 bits, holds the last correctly framed byte.
REQ-007 Port valid, output, 1 bit, is a 1-cycle pulse when data is updated.
REQ-008 Port pending, output, 1 bit, is high from valid until ack.
REQ-009 Port receiving, output, 1 bit, is high in any state other than IDLE.
REQ-010 Port uart_ferr, output, 1 bit, is a 1-cycle framing-error pulse.
REQ-011 Port uart_ovf, output, 1 bit, is a 1-cycle overrun pulse.

Function
REQ-012 UART_RX SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rx_s, and both flops reset to 1.
REQ-013 Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), with no parity.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, STOP and BREAK, plus a cycle counter and a 3-bit bit index.
REQ-015 IDLE: rx_s==0 SHALL move the FSM to START with the counter cleared.
REQ-016 START: at counter == CLKS_PER_BIT/2-1 (integer divide), rx_s==0 moves to DATA with the counter cleared; rx_s==1 is a glitch and returns to IDLE with no output.
REQ-017 DATA: at counter == CLKS_PER_BIT-1, rx_s SHALL shift into the MSB of the shift register, shifting right, the counter clears and the index increments; after index 7 is sampled the FSM moves to STOP.
REQ-018 STOP: at counter == CLKS_PER_BIT-1, rx_s==1 loads data from the shift register, pulses valid and returns to IDLE.
REQ-019 STOP: at counter == CLKS_PER_BIT-1, rx_s==0 pulses uart_ferr, leaves data unchanged, does not pulse valid, and enters BREAK.
REQ-020 BREAK SHALL stay until rx_s==1, then go to IDLE; a line held low therefore yields exactly one uart_ferr.
REQ-021 pending SHALL be set on valid and cleared on ack; simultaneous valid and ack leaves pending = 1.
REQ-022 valid while pending==1 and ack==0 SHALL pulse uart_ovf in the same cycle, and data is overwritten with the new byte.
REQ-023 ack while pending==0 SHALL have no effect.
REQ-024 valid, uart_ferr and uart_ovf SHALL each be high for exactly one cycle per event and never high in consecutive cycles from one frame.
REQ-025 A back-to-back frame whose start bit immediately follows the stop bit SHALL be received without loss.

Reset
REQ-026 rst SHALL force: state IDLE, counter 0, index 0, shift register 0x00, data 0x00, valid 0, pending 0, receiving 0, uart_ferr 0, uart_ovf 0, synchronizer flops 1.
REQ-027 rst asserted mid-frame SHALL abort the frame with no valid or uart_ferr; after rst the next falling edge is treated as a new start bit.

Verification (CLKS_PER_BIT=16)
REQ-028 Frame 0xA5 driven at 16 clk/bit -> valid pulses once 150-156 cycles after the start edge, data = 0xA5, pending = 1, uart_ferr = 0.
REQ-029 Low pulse of 4 cycles on an idle line -> receiving rises, then returns to 0; no valid and no uart_ferr.
REQ-030 Frame 0x3C with the stop bit driven 0, then the line held low for 40 cycles -> exactly one uart_ferr pulse, data unchanged, FSM back in IDLE after the line goes high.
REQ-031 Frames 0x11 then 0x22 back-to-back with no ack -> second valid coincides with the uart_ovf pulse, data = 0x22; repeated with ack in the second valid cycle -> no uart_ovf.
REQ-032 rst pulsed during data bit 4 of frame 0xFF -> all outputs reset, no valid; the following frame 0x5A is received correctly.
REQ-033 Loopback from an Rs232Tx at matching baud sending 0x00, 0xFF, 0x55 -> three valid pulses with bytes matching in order.
